spi_rx_stream: RTL and testbench

Parametrised SPI slave receiver: oversamples SCK/CS/MISO on `sys_clk`, supports all four SPI modes and a configurable word width, and buffers completed words in a small FIFO drained through a valid/ready handshake. Successor to the fixed 16-bit, mode-0, single-register receiver. Sits between the board SPI pins and the sample-processing logic.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_rx_fifo.sv | 71 +++++++
 rtl/spi_rx_stream.sv | 147 ++++++++++++++
 tb/tb_spi_rx_stream.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI stream receiver.
// Mode bit positions, FSM state encoding and the default synchroniser depth.
package spi_pkg;

  localparam int CPOL_BIT = 1;
  localparam int CPHA_BIT = 0;
  localparam int SYNC_STAGES_DEFAULT = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead FIFO: a push is visible at the head the same edge; a pop advances the head on the accepting edge.
// A push into a full FIFO without a simultaneous pop is dropped; the caller flags the overflow.
module spi_rx_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_dat,
  input  logic                          pop,
  output logic [DATA_W-1:0]             pop_dat,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign level   = cnt_q;
  // Head is forced to zero when empty so stale storage never leaks after reset.
  assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/spi_rx_stream.sv
// SPI slave receiver, all four modes: word pushed SYNC_STAGES+1 sys_clk edges after its last sample SCK edge.
// Words queue in a show-ahead FIFO drained by data_valid/data_ready; words arriving when full are dropped and flagged.
module spi_rx_stream
  import spi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int MSB_FIRST   = 1
) (
  input  logic                        sys_clk,
  input  logic                        rst_n,
  input  logic                        sck,
  input  logic                        cs,
  input  logic                        miso,
  input  logic [1:0]                  mode,
  output logic [DATA_W-1:0]           data,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        overflow,
  output logic                        frame_err,
  input  logic                        clr_err,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
  logic                   sck_q, sck_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]      shreg_q, shreg_d, shreg_next;
  logic [1:0]             mode_q, mode_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   fresh_q, fresh_d;

  logic sck_s, cs_s, miso_s;
  logic sample, push, new_frame_err, new_overflow;
  logic fifo_full, fifo_empty, fifo_pop;

  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign miso_s = miso_sync_q[SYNC_STAGES-1];

  assign fifo_pop   = data_valid & data_ready;
  assign data_valid = ~fifo_empty;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    miso_sync_d = {miso_sync_q[SYNC_STAGES-2:0], miso};
    sck_d       = sck_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    mode_d      = mode_q;
    fresh_d     = fresh_q & ~cs_s;
    push        = 1'b0;
    new_frame_err = 1'b0;

    // Rising edge samples when CPOL==CPHA, falling edge otherwise.
    sample = (mode_q[CPOL_BIT] ^ mode_q[CPHA_BIT]) ? (~sck_s & sck_q) : (sck_s & ~sck_q);
    shreg_next = (MSB_FIRST != 0) ? {shreg_q[DATA_W-2:0], miso_s}
                                  : {miso_s, shreg_q[DATA_W-1:1]};

    case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          mode_d  = mode;
        end
      end
      ACTIVE: begin
        if (cs_s) begin
          state_d = IDLE;
          cnt_d   = '0;
          // A frame joined mid-way after reset is the host's to restart, not an error.
          new_frame_err = (cnt_q != '0) & ~fresh_q;
        end else if (sample) begin
          shreg_d = shreg_next;
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            push  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    new_overflow = push & fifo_full & ~fifo_pop;
    overflow_d   = (overflow_q & ~clr_err) | new_overflow;
    frame_err_d  = (frame_err_q & ~clr_err) | new_frame_err;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      miso_sync_q <= '0;
      sck_q       <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      mode_q      <= 2'b00;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      fresh_q     <= 1'b1;
    end else begin
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      miso_sync_q <= miso_sync_d;
      sck_q       <= sck_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      mode_q      <= mode_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      fresh_q     <= fresh_d;
    end
  end

  spi_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (sys_clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (shreg_next),
    .pop      (fifo_pop),
    .pop_dat  (data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

endmodule

// File: tb/tb_spi_rx_stream.sv
// Directed bench for spi_rx_stream: 16-bit words, 4-deep FIFO, 2 sync stages, MSB first.
module tb_spi_rx_stream;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs = 1'b1;
  logic        miso = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        data_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [15:0] data;
  logic        data_valid;
  logic        overflow;
  logic        frame_err;
  logic [2:0]  level;

  int n_chk = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  spi_rx_stream #(
    .DATA_W      (16),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2),
    .MSB_FIRST   (1)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs         (cs),
    .miso       (miso),
    .mode       (mode),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_err    (clr_err),
    .level      (level)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge sys_clk);
  endtask

  // Drive the top nbits of w in SPI mode m; pop_last raises data_ready for exactly the push edge of the last bit (CPHA=0 only).
  task automatic send_bits(input logic [15:0] w, input logic [1:0] m, input int nbits, input bit pop_last);
    for (int i = 15; i > 15 - nbits; i--) begin
      if (!m[0]) begin
        miso = w[i];
        half();
        sck = ~m[1];
        if (pop_last && i == 16 - nbits) begin
          repeat (2) @(negedge sys_clk);
          data_ready = 1'b1;
          @(negedge sys_clk);
          data_ready = 1'b0;
          @(negedge sys_clk);
        end else begin
          half();
        end
        sck = m[1];
      end else begin
        sck  = ~m[1];
        miso = w[i];
        half();
        sck = m[1];
        half();
      end
    end
  endtask

  task automatic begin_frame(input logic [1:0] mpin, input logic idle);
    mode = mpin;
    sck  = idle;
    repeat (6) @(negedge sys_clk);
    cs = 1'b0;
    repeat (6) @(negedge sys_clk);
  endtask

  task automatic end_frame();
    repeat (4) @(negedge sys_clk);
    cs = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, 32'(data_valid), 32'h1);
    chk({tag, "_data"}, 32'(data), 32'(exp));
    data_ready = 1'b1;
    @(negedge sys_clk);
    data_ready = 1'b0;
  endtask

  initial begin
    logic [1:0] mm;

    repeat (3) @(negedge sys_clk);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    // Mode 0 single word
    begin_frame(2'b00, 1'b0);
    send_bits(16'hA5C3, 2'b00, 16, 1'b0);
    end_frame();
    chk("m0_data", 32'(data), 32'hA5C3);
    chk("m0_valid", 32'(data_valid), 32'h1);
    chk("m0_level", 32'(level), 32'h1);
    chk("m0_overflow", 32'(overflow), 32'h0);
    chk("m0_frame_err", 32'(frame_err), 32'h0);
    pop_check("m0_pop", 16'hA5C3);
    chk("m0_level_after", 32'(level), 32'h0);

    // Each mode with matching timing
    for (int m = 0; m < 4; m++) begin
      mm = m[1:0];
      begin_frame(mm, mm[1]);
      send_bits(16'h1234, mm, 16, 1'b0);
      end_frame();
      pop_check($sformatf("mode%0d", m), 16'h1234);
    end

    // Receiver set to sample falling edges while the host drives mode-0 timing: every bit shifts by one
    begin_frame(2'b01, 1'b0);
    send_bits(16'h1234, 2'b00, 16, 1'b0);
    end_frame();
    pop_check("wrong_edge", 16'h2468);

    // Burst of 6 into a 4-deep FIFO with no consumer
    begin_frame(2'b00, 1'b0);
    for (int k = 1; k <= 6; k++) send_bits(16'(k), 2'b00, 16, 1'b0);
    end_frame();
    chk("burst_level", 32'(level), 32'h4);
    chk("burst_overflow", 32'(overflow), 32'h1);
    for (int k = 1; k <= 4; k++) pop_check($sformatf("burst_pop%0d", k), 16'(k));
    chk("burst_level_drained", 32'(level), 32'h0);
    chk("burst_valid_drained", 32'(data_valid), 32'h0);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'h0);

    // Push into a full FIFO on the same edge as a pop
    begin_frame(2'b00, 1'b0);
    for (int k = 1; k <= 4; k++) send_bits(16'(k), 2'b00, 16, 1'b0);
    chk("full_level", 32'(level), 32'h4);
    send_bits(16'h0005, 2'b00, 16, 1'b1);
    end_frame();
    chk("fullpop_level", 32'(level), 32'h4);
    chk("fullpop_overflow", 32'(overflow), 32'h0);
    for (int k = 2; k <= 5; k++) pop_check($sformatf("fullpop%0d", k), 16'(k));
    chk("fullpop_level_drained", 32'(level), 32'h0);

    // Partial frame of 9 bits
    begin_frame(2'b00, 1'b0);
    send_bits(16'hFF80, 2'b00, 9, 1'b0);
    end_frame();
    chk("partial_frame_err", 32'(frame_err), 32'h1);
    chk("partial_level", 32'(level), 32'h0);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    chk("frame_err_cleared", 32'(frame_err), 32'h0);

    // clr_err on the very edge the new frame error is recorded
    begin_frame(2'b00, 1'b0);
    send_bits(16'hFF80, 2'b00, 9, 1'b0);
    repeat (4) @(negedge sys_clk);
    cs = 1'b1;
    repeat (2) @(negedge sys_clk);
    clr_err = 1'b1;
    @(negedge sys_clk);
    clr_err = 1'b0;
    repeat (4) @(negedge sys_clk);
    chk("clr_vs_new_err", 32'(frame_err), 32'h1);

    // Reset mid-word with two words queued
    begin_frame(2'b00, 1'b0);
    send_bits(16'h1111, 2'b00, 16, 1'b0);
    send_bits(16'h2222, 2'b00, 16, 1'b0);
    send_bits(16'h3333, 2'b00, 8, 1'b0);
    chk("pre_rst_level", 32'(level), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 32'h0);
    chk("mid_rst_valid", 32'(data_valid), 32'h0);
    chk("mid_rst_level", 32'(level), 32'h0);
    chk("mid_rst_overflow", 32'(overflow), 32'h0);
    chk("mid_rst_frame_err", 32'(frame_err), 32'h0);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    end_frame();
    chk("post_rst_frame_err", 32'(frame_err), 32'h0);
    chk("post_rst_level", 32'(level), 32'h0);
    begin_frame(2'b00, 1'b0);
    send_bits(16'hBEEF, 2'b00, 16, 1'b0);
    end_frame();
    chk("post_rst_word_level", 32'(level), 32'h1);
    pop_check("post_rst_word", 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
